x2150_print_seq: RTL and testbench



---
 rtl/x2150_pkg.sv | 26 ++
 rtl/x2150_ptimer.sv | 35 +++
 rtl/x2150_print_seq.sv | 169 ++++++++++++++++
 tb/tb_x2150_print_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/x2150_pkg.sv
// Shared types and constants for the 2150 console typewriter print sequencer.
package x2150_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT      = 3'd1,
    ST_SHIFT_WAIT = 3'd2,
    ST_PRINT      = 3'd3,
    ST_PRINT_WAIT = 3'd4
  } state_t;

  localparam int DEF_SHIFT_CYCLES = 8;
  localparam int DEF_SHIFT_SETTLE = 16;
  localparam int DEF_PRINT_CYCLES = 8;
  localparam int DEF_TIMEOUT      = 255;
  localparam int DEF_CW           = 8;

  // Bit positions of the tilt/rotate magnets within the 6-bit code {t1,t2,r1,r2,r2a,r5}.
  localparam int TT_T1  = 5;
  localparam int TT_T2  = 4;
  localparam int TT_R1  = 3;
  localparam int TT_R2  = 2;
  localparam int TT_R2A = 1;
  localparam int TT_R5  = 0;

endpackage

// File: rtl/x2150_ptimer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module x2150_ptimer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/x2150_print_seq.sv
// Print-cycle sequencer: shifts case if needed, then fires tilt/rotate and print magnets,
// and waits for the cycle-complete contact with a timeout into a sticky error.
module x2150_print_seq
  import x2150_pkg::*;
#(
  parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES,
  parameter int SHIFT_SETTLE = DEF_SHIFT_SETTLE,
  parameter int PRINT_CYCLES = DEF_PRINT_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CW           = DEF_CW
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [5:0] i_tt,
  input  logic       i_lower,
  input  logic       i_upper,
  input  logic       i_cycle_done,
  input  logic       i_err_clr,
  output logic [5:0] o_tilt_rotate,
  output logic       o_print_magnet,
  output logic       o_upshift,
  output logic       o_downshift,
  output logic       o_case_upper,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  state_t        state_q, state_d;
  logic [5:0]    tt_q, tt_d;
  logic          up_q, up_d;
  logic          case_upper_q, case_upper_d;
  logic          case_known_q, case_known_d;
  logic          err_q, err_d;
  logic [5:0]    tr_q;
  logic          pm_q, ups_q, dns_q;

  logic          accept;
  logic          err_set;
  logic          done_pulse;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_zero;

  x2150_ptimer #(.CW(CW)) u_timer (
    .clk        (i_clk),
    .rst        (i_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  assign accept = i_valid & o_ready;
  assign tt_d   = accept ? i_tt    : tt_q;
  assign up_d   = accept ? i_upper : up_q;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    err_set      = 1'b0;
    done_pulse   = 1'b0;
    case_upper_d = case_upper_q;
    case_known_d = case_known_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_lower && i_upper) begin
            err_set = 1'b1;
          end else if ((i_lower ^ i_upper) &&
                       (!case_known_q || (i_upper != case_upper_q))) begin
            state_d  = ST_SHIFT;
            tmr_load = 1'b1;
            tmr_val  = CW'(SHIFT_CYCLES - 1);
          end else begin
            state_d  = ST_PRINT;
            tmr_load = 1'b1;
            tmr_val  = CW'(PRINT_CYCLES - 1);
          end
        end
      end
      ST_SHIFT: begin
        if (tmr_zero) begin
          state_d      = ST_SHIFT_WAIT;
          tmr_load     = 1'b1;
          tmr_val      = CW'(SHIFT_SETTLE - 1);
          case_upper_d = up_q;
          case_known_d = 1'b1;
        end
      end
      ST_SHIFT_WAIT: begin
        if (tmr_zero) begin
          state_d  = ST_PRINT;
          tmr_load = 1'b1;
          tmr_val  = CW'(PRINT_CYCLES - 1);
        end
      end
      ST_PRINT: begin
        if (tmr_zero) begin
          state_d  = ST_PRINT_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CW'(TIMEOUT - 1);
        end
      end
      ST_PRINT_WAIT: begin
        // A completion arriving on the last allowed cycle still counts as success.
        if (i_cycle_done) begin
          state_d    = ST_IDLE;
          done_pulse = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  // Drives are registered from the next state so they line up exactly with the state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      tt_q         <= '0;
      up_q         <= 1'b0;
      case_upper_q <= 1'b0;
      case_known_q <= 1'b0;
      err_q        <= 1'b0;
      tr_q         <= '0;
      pm_q         <= 1'b0;
      ups_q        <= 1'b0;
      dns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tt_q         <= tt_d;
      up_q         <= up_d;
      case_upper_q <= case_upper_d;
      case_known_q <= case_known_d;
      err_q        <= err_d;
      tr_q         <= (state_d == ST_PRINT) ? tt_d : 6'd0;
      pm_q         <= (state_d == ST_PRINT);
      ups_q        <= (state_d == ST_SHIFT) &  up_d;
      dns_q        <= (state_d == ST_SHIFT) & ~up_d;
    end
  end

  assign o_ready        = (state_q == ST_IDLE) & ~err_q;
  assign o_tilt_rotate  = tr_q;
  assign o_print_magnet = pm_q;
  assign o_upshift      = ups_q;
  assign o_downshift    = dns_q;
  assign o_case_upper   = case_upper_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_pulse;
  assign o_error        = err_q;

endmodule

// File: tb/tb_x2150_print_seq.sv
// Directed bench for the print sequencer: shift/print timing, timeout error, reset, done qualification.
module tb_x2150_print_seq;

  logic       i_clk = 1'b0;
  logic       i_reset, i_valid, i_lower, i_upper, i_cycle_done, i_err_clr;
  logic [5:0] i_tt;
  logic       o_ready, o_print_magnet, o_upshift, o_downshift;
  logic       o_case_upper, o_busy, o_done, o_error;
  logic [5:0] o_tilt_rotate;

  int n_cmp = 0;
  int n_mis = 0;

  x2150_print_seq dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_tt           (i_tt),
    .i_lower        (i_lower),
    .i_upper        (i_upper),
    .i_cycle_done   (i_cycle_done),
    .i_err_clr      (i_err_clr),
    .o_tilt_rotate  (o_tilt_rotate),
    .o_print_magnet (o_print_magnet),
    .o_upshift      (o_upshift),
    .o_downshift    (o_downshift),
    .o_case_upper   (o_case_upper),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Checks n consecutive active cycles; starts and ends 1ns after a rising edge.
  task automatic hold(input string tag, input int n, input logic up, input logic dn,
                      input logic pm, input logic [5:0] tt);
    for (int i = 0; i < n; i++) begin
      #4;
      chk({tag, " up"},   32'(o_upshift),      32'(up));
      chk({tag, " dn"},   32'(o_downshift),    32'(dn));
      chk({tag, " pm"},   32'(o_print_magnet), 32'(pm));
      chk({tag, " tt"},   32'(o_tilt_rotate),  32'(tt));
      chk({tag, " busy"}, 32'(o_busy),         32'd1);
      chk({tag, " done"}, 32'(o_done),         32'd0);
      tick();
    end
  endtask

  task automatic accept_char(input logic [5:0] tt, input logic lo, input logic up);
    i_valid = 1'b1; i_tt = tt; i_lower = lo; i_upper = up;
    #4;
    chk("ready before accept", 32'(o_ready), 32'd1);
    chk("idle before accept",  32'(o_busy),  32'd0);
    chk("no done in idle",     32'(o_done),  32'd0);
    tick();
    i_valid = 1'b0; i_lower = 1'b0; i_upper = 1'b0;
  endtask

  // Waits n PRINT_WAIT cycles, then raises the contact and expects the done pulse.
  task automatic finish(input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      chk("wait no done", 32'(o_done), 32'd0);
      chk("wait busy",    32'(o_busy), 32'd1);
      tick();
    end
    i_cycle_done = 1'b1;
    #4;
    chk("done pulse", 32'(o_done), 32'd1);
    tick();
    i_cycle_done = 1'b0;
  endtask

  initial begin
    logic seen_done;
    logic err_at_last;
    i_reset = 1'b1; i_valid = 1'b0; i_tt = '0; i_lower = 1'b0; i_upper = 1'b0;
    i_cycle_done = 1'b0; i_err_clr = 1'b0;
    #22;
    chk("rst ready", 32'(o_ready),        32'd1);
    chk("rst busy",  32'(o_busy),         32'd0);
    chk("rst err",   32'(o_error),        32'd0);
    chk("rst case",  32'(o_case_upper),   32'd0);
    chk("rst pm",    32'(o_print_magnet), 32'd0);
    chk("rst drv",   32'({o_upshift, o_downshift, o_tilt_rotate}), 32'd0);
    tick();
    i_reset = 1'b0;
    tick();

    // 1: first lower char always shifts down
    accept_char(6'h15, 1'b1, 1'b0);
    hold("t1 shift", 8, 1'b0, 1'b1, 1'b0, 6'h00);
    hold("t1 settle", 16, 1'b0, 1'b0, 1'b0, 6'h00);
    hold("t1 print", 8, 1'b0, 1'b0, 1'b1, 6'h15);
    finish(3);
    chk("t1 case lower", 32'(o_case_upper), 32'd0);

    // 2: lower again, print starts right away
    accept_char(6'h2A, 1'b1, 1'b0);
    hold("t2 print", 8, 1'b0, 1'b0, 1'b1, 6'h2A);
    finish(0);

    // 3: upper char shifts up, then a caseless char keeps upper
    accept_char(6'h07, 1'b0, 1'b1);
    hold("t3 shift", 7, 1'b1, 1'b0, 1'b0, 6'h00);
    #4;
    chk("t3 last shift up", 32'(o_upshift),    32'd1);
    chk("t3 case in shift", 32'(o_case_upper), 32'd0);
    tick();
    #4;
    chk("t3 case after shift", 32'(o_case_upper), 32'd1);
    chk("t3 up off",           32'(o_upshift),    32'd0);
    tick();
    hold("t3 settle", 15, 1'b0, 1'b0, 1'b0, 6'h00);
    hold("t3 print", 8, 1'b0, 1'b0, 1'b1, 6'h07);
    finish(1);
    accept_char(6'h00, 1'b0, 1'b0);
    hold("t3 caseless print", 8, 1'b0, 1'b0, 1'b1, 6'h00);
    finish(0);
    chk("t3 case kept", 32'(o_case_upper), 32'd1);

    // 4: timeout into sticky error, clear, set-wins-over-clear
    accept_char(6'h3F, 1'b0, 1'b1);
    hold("t4 print", 8, 1'b0, 1'b0, 1'b1, 6'h3F);
    seen_done = 1'b0;
    err_at_last = 1'b1;
    for (int i = 0; i < 255; i++) begin
      #4;
      seen_done = seen_done | o_done;
      if (i == 254) err_at_last = o_error;
      tick();
    end
    chk("t4 no done in wait", 32'(seen_done),   32'd0);
    chk("t4 no err at 254",   32'(err_at_last), 32'd0);
    #4;
    chk("t4 err set",   32'(o_error), 32'd1);
    chk("t4 not ready", 32'(o_ready), 32'd0);
    chk("t4 idle",      32'(o_busy),  32'd0);
    chk("t4 no done",   32'(o_done),  32'd0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    #4;
    chk("t4 err cleared", 32'(o_error), 32'd0);
    chk("t4 ready again", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_lower = 1'b1; i_upper = 1'b1; i_err_clr = 1'b1; i_tt = 6'h01;
    tick();
    i_valid = 1'b0; i_lower = 1'b0; i_upper = 1'b0; i_err_clr = 1'b0;
    #4;
    chk("t4 set wins",    32'(o_error),      32'd1);
    chk("t4 no print",    32'(o_busy),       32'd0);
    chk("t4 case intact", 32'(o_case_upper), 32'd1);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;

    // 5: reset during 4th print cycle
    accept_char(6'h11, 1'b0, 1'b1);
    hold("t5 print", 3, 1'b0, 1'b0, 1'b1, 6'h11);
    #2;
    i_reset = 1'b1;
    #1;
    chk("t5 pm dropped", 32'(o_print_magnet), 32'd0);
    chk("t5 tt dropped", 32'(o_tilt_rotate),  32'd0);
    chk("t5 idle",       32'(o_busy),         32'd0);
    chk("t5 case reset", 32'(o_case_upper),   32'd0);
    tick();
    i_reset = 1'b0;
    tick();
    accept_char(6'h11, 1'b0, 1'b1);
    hold("t5 reshift", 8, 1'b1, 1'b0, 1'b0, 6'h00);
    hold("t5 settle", 16, 1'b0, 1'b0, 1'b0, 6'h00);
    hold("t5 print2", 8, 1'b0, 1'b0, 1'b1, 6'h11);
    finish(0);

    // 6: contact high during PRINT is ignored
    i_cycle_done = 1'b1;
    accept_char(6'h22, 1'b0, 1'b1);
    i_cycle_done = 1'b1;
    hold("t6 print", 8, 1'b0, 1'b0, 1'b1, 6'h22);
    i_cycle_done = 1'b0;
    finish(2);
    #4;
    chk("t6 ready after", 32'(o_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
